// File: rtl/tl_ul_sram_responder.sv
// TL-UL manager endpoint: single-beat Get/PutFull/PutPartial against an internal word SRAM,
// one registered D response slot that reloads back-to-back when D drains in the same cycle.
module tl_ul_sram_responder #(
    parameter logic [30:0] BASE  = 31'h0800_0000,
    parameter int unsigned DEPTH = 256
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        a_valid,
    output logic        a_ready,
    input  logic [2:0]  a_opcode,
    input  logic [2:0]  a_param,
    input  logic [2:0]  a_size,
    input  logic [4:0]  a_source,
    input  logic [30:0] a_address,
    input  logic [3:0]  a_mask,
    input  logic [31:0] a_data,
    input  logic        a_corrupt,

    output logic        d_valid,
    input  logic        d_ready,
    output logic [2:0]  d_opcode,
    output logic [1:0]  d_param,
    output logic [2:0]  d_size,
    output logic [4:0]  d_source,
    output logic        d_sink,
    output logic        d_denied,
    output logic [31:0] d_data,
    output logic        d_corrupt
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic {StEmpty, StFull} rsp_state_e;

    rsp_state_e  state_q, state_d;
    logic [2:0]  rsp_opcode_q;
    logic [2:0]  rsp_size_q;
    logic [4:0]  rsp_source_q;
    logic        rsp_denied_q;
    logic [31:0] rsp_data_q;
    logic        rsp_corrupt_q;
    logic [15:0] corrupt_cnt_q;

    logic [31:0] mem [DEPTH];

    logic          a_fire, d_fire;
    logic          is_put, is_get, in_range, aligned, mask_ok, legal;
    logic [3:0]    lane_mask;
    logic [AW-1:0] widx;
    logic          mem_we;

    assign a_ready = (state_q == StEmpty) | d_ready;
    assign d_valid = (state_q == StFull);
    assign a_fire  = a_valid & a_ready;
    assign d_fire  = d_valid & d_ready;

    // BASE is aligned to the window size, so the range check is a compare of the upper bits
    // and the word index is simply the address bits just above the byte offset.
    assign in_range = (a_address[30:AW+2] == BASE[30:AW+2]);
    assign widx     = a_address[AW+1:2];

    always_comb begin
        is_put    = (a_opcode == 3'd0) || (a_opcode == 3'd1);
        is_get    = (a_opcode == 3'd4);
        lane_mask = 4'h0;
        aligned   = 1'b0;
        case (a_size)
            3'd0: begin
                lane_mask = 4'b0001 << a_address[1:0];
                aligned   = 1'b1;
            end
            3'd1: begin
                lane_mask = 4'b0011 << a_address[1:0];
                aligned   = ~a_address[0];
            end
            3'd2: begin
                lane_mask = 4'hF;
                aligned   = (a_address[1:0] == 2'b00);
            end
            default: begin
                lane_mask = 4'h0;
                aligned   = 1'b0;
            end
        endcase
        if (a_opcode == 3'd1) begin
            mask_ok = ((a_mask & ~lane_mask) == 4'h0);
        end else begin
            mask_ok = (a_mask == lane_mask);
        end
        legal = (is_put | is_get) && (a_param == 3'd0) && in_range && aligned && mask_ok;
    end

    always_comb begin
        state_d = state_q;
        if (a_fire) begin
            state_d = StFull;
        end else if (d_fire) begin
            state_d = StEmpty;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= StEmpty;
            rsp_opcode_q  <= 3'd0;
            rsp_size_q    <= 3'd0;
            rsp_source_q  <= 5'd0;
            rsp_denied_q  <= 1'b0;
            rsp_data_q    <= 32'h0;
            rsp_corrupt_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (a_fire) begin
                rsp_opcode_q  <= is_put ? 3'd0 : 3'd1;
                rsp_size_q    <= a_size;
                rsp_source_q  <= a_source;
                rsp_denied_q  <= ~legal;
                rsp_data_q    <= (legal && is_get) ? mem[widx] : 32'h0;
                rsp_corrupt_q <= ~legal & ~is_put;
            end
        end
    end

    // Poisoned write data is dropped but still acknowledged; the count is for debug only.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            corrupt_cnt_q <= 16'd0;
        end else if (a_fire && legal && is_put && a_corrupt) begin
            corrupt_cnt_q <= corrupt_cnt_q + 16'd1;
        end
    end

    assign mem_we = a_fire & legal & is_put & ~a_corrupt & ~reset;

    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (a_mask[b]) begin
                    mem[widx][8*b +: 8] <= a_data[8*b +: 8];
                end
            end
        end
    end

    assign d_opcode  = rsp_opcode_q;
    assign d_param   = 2'b00;
    assign d_size    = rsp_size_q;
    assign d_source  = rsp_source_q;
    assign d_sink    = 1'b0;
    assign d_denied  = rsp_denied_q;
    assign d_data    = rsp_data_q;
    assign d_corrupt = rsp_corrupt_q;

endmodule
